// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 4;

    // Controller states. Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_pkg

// File: rtl/sub_bit.sv
// Combinational full-subtractor cell: a - b - bin -> difference d, borrow bout.
module sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Borrow out when b exceeds a, or when a == b and a borrow is pending.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : sub_bit

// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = (num1 - num2) mod 2^WIDTH, bout = num1 < num2.
// One bit per clock, LSB first, with a start/busy/done handshake.
//
// Handshake: start is sampled on every rising edge but only acted on in IDLE
// or DONE; there it captures num1/num2 and the FSM enters RUN. busy is high
// exactly while in RUN (start is ignored then). done is high for the single
// DONE cycle, during which out/bout carry the fresh result; out/bout then hold
// until the next done. A start seen in DONE begins the next operation with no
// idle gap.
module sub_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             bout
);

    // Bit-counter width, derived from WIDTH.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // The result register keeps the WIDTH-1 difference bits produced so far;
    // the last bit comes straight from the cell and is merged on the final
    // step, so the full result never needs an extra shift.
    logic [WIDTH-2:0] r_q, r_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             bout_q, bout_d;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] r_full;

    // One full-subtractor cell handles the current LSB pair and running borrow.
    sub_bit u_sub_bit (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Result after shifting this step's difference bit into the MSB.
    assign r_full = {bit_d, r_q};

    // Next-state, datapath and result-register update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = num1;
                    b_d     = num2;
                    r_d     = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = r_full[WIDTH-1:1];
                br_d  = bit_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    out_d   = r_full;
                    bout_d  = bit_bout;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            bout_q  <= bout_d;
        end
    end

    // Status and result outputs decode directly from registers.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        out  = out_q;
        bout = bout_q;
    end

endmodule : sub_serial

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed boundary cases, reset abort,
// back-to-back starts, an exhaustive operand sweep and random traffic.
module tb_sub_serial;
    import sub_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         bout;

    // Scoreboard state.
    logic [W:0]   exp_q[$];
    logic [W-1:0] n1_q[$];
    logic [W-1:0] n2_q[$];
    logic [W:0]   held;
    int           checks;
    int           failures;

    sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .num1  (num1),
        .num2  (num2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .bout  (bout)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: {borrow, difference} is the (W+1)-bit two's complement
    // of num1 - num2.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int diff;
        diff = int'(a) - int'(b);
        return (W+1)'(diff);
    endfunction

    // Monitor: pops and compares every time the DUT presents done.
    always @(negedge clk) begin
        logic [W:0]   e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        if (!rst && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got out=%0d bout=%0d, required no done", out, bout);
            end else begin
                e = exp_q.pop_front();
                a = n1_q.pop_front();
                b = n2_q.pop_front();
                if ({bout, out} !== e) begin
                    failures++;
                    $display("FAIL result %0d-%0d got bout=%0d out=%0d, required bout=%0d out=%0d",
                             a, b, bout, out, e[W], e[W-1:0]);
                end
                checks++;
                s = out + b;
                if (s !== a) begin
                    failures++;
                    $display("FAIL add_crosscheck out+num2=%0d, required %0d", s, a);
                end
                held = e;
            end
        end
    end

    // Driver: present one operation with start, consume the accepting edge,
    // then scramble the operand pins to prove they are not resampled.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        num1  = a;
        num2  = b;
        exp_q.push_back(model(a, b));
        n1_q.push_back(a);
        n2_q.push_back(b);
        @(posedge clk);
        #1;
        start = 1'b0;
        num1  = W'($urandom_range(0, (1 << W) - 1));
        num2  = W'($urandom_range(0, (1 << W) - 1));
    endtask

    // Wait for done after issue(), checking latency, busy span and that the
    // visible result is held mid-operation. poke pulses start while busy.
    task automatic wait_done(input bit poke);
        int lat;
        int busy_cycles;
        bit seen;
        lat         = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        while (!seen && lat < 4 * W + 8) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1'b1;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_in_done got %0b, required 0", busy);
                end
            end else begin
                if (busy === 1'b1) busy_cycles++;
                checks++;
                if ({bout, out} !== held) begin
                    failures++;
                    $display("FAIL held_result got %0d, required %0d", {bout, out}, held);
                end
            end
            if (poke && lat == 2) begin
                start = 1'b1;
                num1  = W'($urandom_range(0, (1 << W) - 1));
                num2  = W'($urandom_range(0, (1 << W) - 1));
            end
            if (poke && lat == 3) start = 1'b0;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout waited %0d cycles, required done at %0d", lat, W + 1);
        end else if (lat != W + 1) begin
            failures++;
            $display("FAIL latency got %0d cycles, required %0d", lat, W + 1);
        end
        checks++;
        if (busy_cycles != W) begin
            failures++;
            $display("FAIL busy_span got %0d cycles, required %0d", busy_cycles, W);
        end
    endtask

    // Check all outputs against fixed values at the current time.
    task automatic check_quiet(input string name, input logic [W-1:0] exp_out, input logic exp_bout);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== exp_out || bout !== exp_bout) begin
            failures++;
            $display("FAIL %s got busy=%0b done=%0b out=%0d bout=%0b, required busy=0 done=0 out=%0d bout=%0b",
                     name, busy, done, out, bout, exp_out, exp_bout);
        end
    endtask

    // Main sequence.
    initial begin
        int gap;
        checks   = 0;
        failures = 0;
        held     = '0;
        rst      = 1'b1;
        start    = 1'b0;
        num1     = '0;
        num2     = '0;

        // Reset then three idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_state", '0, 1'b0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("idle_after_reset", '0, 1'b0);
        end

        // Directed operations, including boundaries.
        @(posedge clk); #1;
        issue(4'd9, 4'd3);  wait_done(1'b0);
        @(posedge clk); #1;
        issue(4'd3, 4'd9);  wait_done(1'b0);
        // Back-to-back start in the done cycle, with a start pulsed during RUN.
        issue(4'd15, 4'd15); wait_done(1'b1);
        @(posedge clk); #1;
        issue(4'd0, 4'd0);  wait_done(1'b0);
        issue(4'd0, 4'd1);  wait_done(1'b0);
        issue(4'd15, 4'd0); wait_done(1'b0);
        issue(4'd7, 4'd2);  wait_done(1'b0);
        repeat (6) begin
            @(negedge clk);
            check_quiet("idle_hold", held[W-1:0], held[W]);
        end

        // Reset on the second RUN cycle aborts the operation.
        @(posedge clk); #1;
        issue(4'd12, 4'd5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        n1_q.delete();
        n2_q.delete();
        held = '0;
        #1;
        check_quiet("reset_abort", '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check_quiet("no_done_after_abort", '0, 1'b0);
        end
        @(posedge clk); #1;
        issue(4'd12, 4'd5); wait_done(1'b0);

        // Exhaustive sweep, back-to-back.
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                issue(W'(i), W'(j));
                wait_done(1'b0);
            end
        end

        // Random traffic with random gaps and random pokes.
        for (int k = 0; k < 60; k++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            if (gap != 0) #1;
            issue(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
            wait_done(1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sub_serial
